rx_sys: RTL and testbench

RX_SYS -- requirements
Module: rx_sys

---
 rtl/rx_sys.sv | 165 ++++++++++++++++
 tb/tb_rx_sys.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sys.sv
`default_nettype none
// ============================================================================
// Module   : rx_sys
// Brief    : 8N1 UART receiver, 16x oversampling with 2-of-3 mid-bit majority,
//            single-entry output register with ready/ack, overrun and framing error.
// Revision : 1.0  initial release
// ============================================================================
module rx_sys #(
    parameter int CLK_DIV = 27
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxPin,
    output logic [7:0] data,
    output logic       ready,
    input  logic       ack,
    output logic       frameErr,
    output logic       overrun
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         sub_q, sub_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               smp7_q, smp7_d;
    logic               smp8_q, smp8_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [7:0]         data_q, data_d;
    logic               ready_q, ready_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;

    logic               rx_s;
    logic               tick;
    logic               maj;
    logic               good;

    assign rx_s = sync2_q;
    assign tick = (div_q == DIV_W'(CLK_DIV - 1));
    // Third vote is the live sample taken on the sub-tick-9 tick itself.
    assign maj  = (smp7_q & smp8_q) | (smp7_q & rx_s) | (smp8_q & rx_s);

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        smp7_d      = smp7_q;
        smp8_d      = smp8_q;
        data_d      = data_q;
        ready_d     = ready_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        good        = 1'b0;
        sync1_d     = rxPin;
        sync2_d     = sync1_q;
        div_d       = tick ? '0 : div_q + DIV_W'(1);

        if (tick) begin
            if (sub_q == 4'd7) smp7_d = rx_s;
            if (sub_q == 4'd8) smp8_d = rx_s;

            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        sub_d   = 4'd1;
                    end
                end
                S_START: begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd9 && maj) begin
                        state_d = S_IDLE;
                    end else if (sub_q == 4'd15) begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end
                end
                S_DATA: begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd9) shift_d = {maj, shift_q[7:1]};
                    if (sub_q == 4'd15) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd9) begin
                        if (maj) begin
                            good    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A new byte wins over a same-cycle ack; only an unacked byte is lost.
        if (good) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            if (ready_q && !ack) overrun_d = 1'b1;
        end else if (ready_q && ack) begin
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            sub_q       <= 4'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            smp7_q      <= 1'b0;
            smp8_q      <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            data_q      <= 8'h00;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            sub_q       <= sub_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            smp7_q      <= smp7_d;
            smp8_q      <= smp8_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data     = data_q;
    assign ready    = ready_q;
    assign frameErr = frame_err_q;
    assign overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_sys.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_sys
// Brief    : Self-checking bench for rx_sys (CLK_DIV=4, 64 clocks per bit).
// Revision : 1.0  initial release
// ============================================================================
module tb_rx_sys;
    localparam int CLK_DIV = 4;
    localparam int BIT_CLK = 16 * CLK_DIV;

    logic       clock = 1'b0;
    logic       reset;
    logic       rxPin;
    logic [7:0] data;
    logic       ready;
    logic       ack;
    logic       frameErr;
    logic       overrun;

    rx_sys #(.CLK_DIV(CLK_DIV)) dut (
        .clock    (clock),
        .reset    (reset),
        .rxPin    (rxPin),
        .data     (data),
        .ready    (ready),
        .ack      (ack),
        .frameErr (frameErr),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   err_seen = 0;
    int   rise_cyc = 0;
    logic ready_prev;

    // Reference model: frame-level view of what the consumer should see.
    logic [7:0] m_data;
    logic       m_ready;
    logic       m_ovr;
    int         err_exp;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (frameErr === 1'b1) err_seen = err_seen + 1;
        if (ready === 1'b1 && ready_prev !== 1'b1) rise_cyc = cyc;
        ready_prev = ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic check_all(input string t);
        @(negedge clock);
        check({t, ".data"},    32'(data),     32'(m_data));
        check({t, ".ready"},   32'(ready),    32'(m_ready));
        check({t, ".overrun"}, 32'(overrun),  32'(m_ovr));
        check({t, ".ferr"},    32'(err_seen), 32'(err_exp));
    endtask

    task automatic model_clear();
        m_data  = 8'h00;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit ok, input bit ack_same);
        if (ok) begin
            if (m_ready && !ack_same) m_ovr = 1'b1;
            m_data  = b;
            m_ready = 1'b1;
        end else begin
            err_exp++;
        end
    endtask

    task automatic drive_bit(input logic v);
        @(posedge clock);
        #1 rxPin = v;
        repeat (BIT_CLK - 1) @(posedge clock);
    endtask

    // Leaves the line at the stop-bit level; caller decides what follows.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
    endtask

    task automatic release_line(input int n);
        #1 rxPin = 1'b1;
        repeat (n) @(posedge clock);
    endtask

    task automatic do_ack();
        @(posedge clock);
        #1 ack = 1'b1;
        @(posedge clock);
        #1 ack = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        model_clear();
    endtask

    initial begin
        int          c0;
        int          lat;
        int          target;
        logic [7:0]  b;
        bit          ok;

        rxPin   = 1'b1;
        ack     = 1'b0;
        reset   = 1'b1;
        err_exp = 0;
        model_clear();
        repeat (4) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst.data",     32'(data),     32'h00);
        check("rst.ready",    32'(ready),    32'h0);
        check("rst.frameErr", 32'(frameErr), 32'h0);
        check("rst.overrun",  32'(overrun),  32'h0);
        release_line(20);

        // Single good frame and its delivery latency
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1, 1'b0);
        release_line(32);
        lat = rise_cyc - c0;
        check("a5.latency_in_window", 32'(lat >= 9 * BIT_CLK && lat <= 10 * BIT_CLK), 32'h1);
        check_all("a5");
        do_ack();
        check_all("a5.ack");

        // Short low glitch must be rejected, then a real frame still decodes
        @(posedge clock);
        #1 rxPin = 1'b0;
        repeat (20) @(posedge clock);
        release_line(80);
        check_all("glitch");
        send_frame(8'h5A, 1'b1);
        model_frame(8'h5A, 1'b1, 1'b0);
        release_line(32);
        check_all("post_glitch");
        do_ack();

        // Bad stop bit followed by a held-low line: exactly one error pulse
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        repeat (3 * BIT_CLK) @(posedge clock);
        release_line(BIT_CLK);
        check_all("break");

        // Back-to-back frames without ack
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1, 1'b0);
        release_line(32);
        check_all("ovr");
        do_ack();
        check_all("ovr.ack");

        // Ack lands on the very edge that loads the second byte
        do_reset();
        release_line(40);
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1, 1'b0);
        target = rise_cyc + 10 * BIT_CLK - 1;
        fork
            send_frame(8'h7E, 1'b1);
            begin
                @(negedge clock);
                while (cyc < target) @(negedge clock);
                ack = 1'b1;
                @(negedge clock);
                ack = 1'b0;
            end
        join
        model_frame(8'h7E, 1'b1, 1'b1);
        release_line(32);
        check_all("ack_same");

        // Reset in the middle of a frame aborts it silently
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * BIT_CLK + BIT_CLK / 2) @(posedge clock);
                #1 reset = 1'b1;
                @(posedge clock);
                #1 reset = 1'b0;
                model_clear();
            end
        join
        release_line(32);
        check_all("mid_rst");
        send_frame(8'h0F, 1'b1);
        model_frame(8'h0F, 1'b1, 1'b0);
        release_line(32);
        check_all("after_rst");

        // Randomized traffic: bytes, stop-bit validity, acks and gaps
        for (int k = 0; k < 12; k++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) do_ack();
            send_frame(b, ok);
            model_frame(b, ok, 1'b0);
            release_line(ok ? 32'($urandom_range(0, 40)) : 32'(BIT_CLK + $urandom_range(0, 40)));
            check_all($sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
